// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the bus arbiters built on it.
package dmem_arbiter_pkg;

  // Sequencer states in front of dmemory.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  // Requester identities: port 0 is the CPU load/store unit, port 1 the debug/DMA loader.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Word address of the LED segment register written by the debug loader.
  localparam logic [31:0] LED_SEG_ADDRESS = 32'h0000_03FC;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin select: on a tie the port that did not win last time wins.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  // Pick a winner among the active requests, alternating on a tie.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = PORT_DBG;
    end else begin
      winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of dmemory: serialises CPU and
// debug/DMA requests, spaces the memory strobes and returns data/completions.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             busy,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] read_address,
  output logic [WIDTH-1:0] write_address,
  output logic [WIDTH-1:0] write_data,
  input  logic [WIDTH-1:0] mem_data
);

  state_t           r_state, w_state_nxt;
  logic             r_last_grant, w_last_grant_nxt;
  logic             r_winner, w_winner_nxt;
  logic             r_we, w_we_nxt;
  logic [WIDTH-1:0] r_addr, w_addr_nxt;
  logic [WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [1:0]       r_done, w_done_nxt;
  logic [1:0]       r_err, w_err_nxt;
  logic             r_mem_read, w_mem_read_nxt;
  logic             r_mem_write, w_mem_write_nxt;
  logic             r_busy, w_busy_nxt;
  logic [WIDTH-1:0] r_rdata0, w_rdata0_nxt;
  logic [WIDTH-1:0] r_rdata1, w_rdata1_nxt;

  logic             w_req0_m, w_req1_m;
  logic             w_pick_valid, w_pick_winner;
  logic             w_sel_we;
  logic [WIDTH-1:0] w_sel_addr, w_sel_wdata;
  logic             w_sel_oob;

  // A port that is being told done/err this cycle still holds its old request,
  // so it is masked out until the following IDLE cycle.
  assign w_req0_m = req0 & ~(r_done[0] | r_err[0]);
  assign w_req1_m = req1 & ~(r_done[1] | r_err[1]);

  rr_pick2 u_pick (
    .req0       (w_req0_m),
    .req1       (w_req1_m),
    .last_grant (r_last_grant),
    .valid      (w_pick_valid),
    .winner     (w_pick_winner)
  );

  assign w_sel_we    = (w_pick_winner == PORT_DBG) ? we1    : we0;
  assign w_sel_addr  = (w_pick_winner == PORT_DBG) ? addr1  : addr0;
  assign w_sel_wdata = (w_pick_winner == PORT_DBG) ? wdata1 : wdata0;
  assign w_sel_oob   = (w_sel_addr >= WIDTH'(DEPTH));

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_winner_nxt     = r_winner;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_done_nxt       = '0;
    w_err_nxt        = '0;
    w_mem_read_nxt   = 1'b0;
    w_mem_write_nxt  = 1'b0;
    w_rdata0_nxt     = r_rdata0;
    w_rdata1_nxt     = r_rdata1;

    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_winner_nxt     = w_pick_winner;
          w_we_nxt         = w_sel_we;
          w_addr_nxt       = w_sel_addr;
          w_wdata_nxt      = w_sel_wdata;
          w_last_grant_nxt = w_pick_winner;
          if (w_sel_oob) begin
            w_err_nxt[w_pick_winner] = 1'b1;
          end else begin
            w_state_nxt     = ACCESS;
            w_mem_write_nxt = w_sel_we;
            w_mem_read_nxt  = ~w_sel_we;
          end
        end
      end
      ACCESS: begin
        if (r_we) begin
          w_done_nxt[r_winner] = 1'b1;
          w_state_nxt          = IDLE;
        end else begin
          w_state_nxt = RDWAIT;
        end
      end
      RDWAIT: begin
        if (r_winner == PORT_DBG) begin
          w_rdata1_nxt = mem_data;
        end else begin
          w_rdata0_nxt = mem_data;
        end
        w_done_nxt[r_winner] = 1'b1;
        w_state_nxt          = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and latched request; reset aborts any transfer silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= PORT_DBG;
      r_winner     <= PORT_CPU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_done       <= '0;
      r_err        <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_busy       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_last_grant <= w_last_grant_nxt;
      r_winner     <= w_winner_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_busy       <= w_busy_nxt;
      r_rdata0     <= w_rdata0_nxt;
      r_rdata1     <= w_rdata1_nxt;
    end
  end

  assign done0         = r_done[0];
  assign done1         = r_done[1];
  assign err0          = r_err[0];
  assign err1          = r_err[1];
  assign rdata0        = r_rdata0;
  assign rdata1        = r_rdata1;
  assign busy          = r_busy;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign read_address  = r_addr;
  assign write_address = r_addr;
  assign write_data    = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural dmemory, per-port request
// queues and a scoreboard of expected completions.
module tb_dmem_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1, we0, we1;
  logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1;
  logic             done0, done1, err0, err1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic             busy, mem_read, mem_write;
  logic [WIDTH-1:0] read_address, write_address, write_data, mem_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0          (req0),
    .req1          (req1),
    .we0           (we0),
    .we1           (we1),
    .addr0         (addr0),
    .addr1         (addr1),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .done0         (done0),
    .done1         (done1),
    .err0          (err0),
    .err1          (err1),
    .rdata0        (rdata0),
    .rdata1        (rdata1),
    .busy          (busy),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .read_address  (read_address),
    .write_address (write_address),
    .write_data    (write_data),
    .mem_data      (mem_data)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_lat;
  } req_t;

  typedef struct {
    bit          err;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          t;
    bit          chk_lat;
  } exp_t;

  req_t        pq0[$], pq1[$];
  exp_t        sb0[$], sb1[$];
  int          order_log[$];
  int          cyc_log[$];
  logic [31:0] shadow [int];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  bit          active [2];
  bit          cmp_seen [2];
  int          strobes;
  bit          s_we;
  logic [31:0] s_addr, s_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    return (i == 5) ? 32'hDEAD_BEEF : (32'hA5A5_0000 ^ 32'(i));
  endfunction

  function automatic logic [31:0] shadow_get(input int a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  // Behavioural dmemory: write on a sampled mem_write, read data one cycle after mem_read.
  logic [31:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_val(i);
    mem_data = '0;
    forever begin
      @(posedge clk);
      if (mem_write) mem[write_address[9:0]] = write_data;
      if (mem_read) mem_data <= mem[read_address[9:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic present(input int p, input req_t r);
    exp_t x;
    x.err     = (r.addr >= 32'(DEPTH));
    x.we      = r.we;
    x.addr    = r.addr;
    x.wdata   = r.wdata;
    x.rdata   = (!r.we && !x.err) ? shadow_get(int'(r.addr)) : 32'h0;
    x.t       = cyc;
    x.chk_lat = r.chk_lat;
    if (r.we && !x.err) shadow[int'(r.addr)] = r.wdata;
    if (p == 0) begin
      req0 = 1'b1; we0 = r.we; addr0 = r.addr; wdata0 = r.wdata;
      sb0.push_back(x);
    end else begin
      req1 = 1'b1; we1 = r.we; addr1 = r.addr; wdata1 = r.wdata;
      sb1.push_back(x);
    end
    active[p] = 1'b1;
  endtask

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      if (active[p] && cmp_seen[p]) begin
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        active[p]   = 1'b0;
        cmp_seen[p] = 1'b0;
      end
      if (!active[p]) begin
        if (p == 0 && pq0.size() > 0) present(0, pq0.pop_front());
        else if (p == 1 && pq1.size() > 0) present(1, pq1.pop_front());
      end
    end
  endtask

  task automatic completion(input int p, input bit is_err);
    exp_t x;
    if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
      check($sformatf("unexpected_cmp_p%0d", p), 32'd1, 32'd0);
    end else begin
      x = (p == 0) ? sb0.pop_front() : sb1.pop_front();
      check($sformatf("kind_p%0d", p), 32'(is_err), 32'(x.err));
      if (x.err) begin
        check("err_nostrobe", 32'(strobes), 32'd0);
      end else begin
        check("strobe_cnt", 32'(strobes), 32'd1);
        check("strobe_dir", 32'(s_we), 32'(x.we));
        check("strobe_addr", s_addr, x.addr);
        if (x.we) check("strobe_wdata", s_wdata, x.wdata);
        else check($sformatf("rdata_p%0d", p), (p == 0) ? rdata0 : rdata1, x.rdata);
      end
      if (x.chk_lat) check("latency", 32'(cyc - x.t), x.err ? 32'd1 : (x.we ? 32'd2 : 32'd3));
    end
    order_log.push_back(p);
    cyc_log.push_back(cyc);
    strobes = 0;
  endtask

  task automatic monitor();
    check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
    if (mem_read || mem_write) begin
      check("addr_pair", read_address, write_address);
      strobes++;
      s_we    = mem_write;
      s_addr  = write_address;
      s_wdata = write_data;
    end
    if (done0 && err0) check("done_err_p0", 32'd1, 32'd0);
    if (done1 && err1) check("done_err_p1", 32'd1, 32'd0);
    if (done0 || err0) begin cmp_seen[0] = 1'b1; completion(0, err0); end
    if (done1 || err1) begin cmp_seen[1] = 1'b1; completion(1, err1); end
    if (reset) strobes = 0;
  endtask

  // One clock: drive just after the rising edge, observe at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (pq0.size() == 0 && pq1.size() == 0 && !active[0] && !active[1] &&
          sb0.size() == 0 && sb1.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    active[0] = 1'b0; active[1] = 1'b0;
    cmp_seen[0] = 1'b0; cmp_seen[1] = 1'b0;
    pq0.delete(); pq1.delete(); sb0.delete(); sb1.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic req_t mk(input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit chk_lat);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.chk_lat = chk_lat;
    return r;
  endfunction

  initial begin
    int base;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    strobes = 0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    active[0] = 1'b0; active[1] = 1'b0; cmp_seen[0] = 1'b0; cmp_seen[1] = 1'b0;

    // Reset values.
    step();
    step();
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_err1", 32'(err1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_read_address", read_address, 32'd0);
    check("rst_write_address", write_address, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    reset = 1'b0;
    step();

    // Single read from port 0.
    base = order_log.size();
    pq0.push_back(mk(1'b0, 32'd5, 32'd0, 1'b1));
    wait_idle(20);
    check("t1_count", 32'(order_log.size() - base), 32'd1);
    check("t1_rdata0", rdata0, 32'hDEAD_BEEF);

    // Write from port 1, then read back on port 0.
    pq1.push_back(mk(1'b1, 32'h3FF, 32'h1234, 1'b1));
    wait_idle(20);
    pq0.push_back(mk(1'b0, 32'h3FF, 32'd0, 1'b1));
    wait_idle(20);
    check("t2_rdata0", rdata0, 32'h1234);

    // Contention from reset: grants alternate starting with port 0.
    apply_reset();
    base = order_log.size();
    pq0.push_back(mk(1'b0, 32'd20, 32'd0, 1'b0));
    pq0.push_back(mk(1'b0, 32'd21, 32'd0, 1'b0));
    pq1.push_back(mk(1'b0, 32'd30, 32'd0, 1'b0));
    pq1.push_back(mk(1'b0, 32'd31, 32'd0, 1'b0));
    wait_idle(60);
    check("t3_count", 32'(order_log.size() - base), 32'd4);
    if (order_log.size() - base == 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("t3_grant%0d", i), 32'(order_log[base + i]), 32'(i % 2));
    end

    // Out-of-range write, then a tie goes to port 1.
    pq0.push_back(mk(1'b1, 32'd1024, 32'hBAD0_BAD0, 1'b1));
    wait_idle(20);
    base = order_log.size();
    pq0.push_back(mk(1'b0, 32'd40, 32'd0, 1'b0));
    pq1.push_back(mk(1'b0, 32'd41, 32'd0, 1'b0));
    wait_idle(40);
    check("t4_count", 32'(order_log.size() - base), 32'd2);
    if (order_log.size() - base == 2) begin
      check("t4_first", 32'(order_log[base]), 32'd1);
      check("t4_second", 32'(order_log[base + 1]), 32'd0);
    end

    // Reset during RDWAIT aborts the read with no completion.
    pq0.push_back(mk(1'b0, 32'd7, 32'd0, 1'b0));
    step();
    step();
    step();
    reset = 1'b1;
    req0 = 1'b0;
    active[0] = 1'b0;
    sb0.delete();
    step();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done0", 32'(done0), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    pq0.push_back(mk(1'b0, 32'd8, 32'd0, 1'b1));
    wait_idle(20);
    check("t5_rdata0", rdata0, init_val(8));

    // Back-to-back writes from port 0, then read both back.
    base = order_log.size();
    pq0.push_back(mk(1'b1, 32'd100, 32'hAAAA_0001, 1'b1));
    pq0.push_back(mk(1'b1, 32'd101, 32'hBBBB_0002, 1'b1));
    wait_idle(30);
    check("t6_count", 32'(order_log.size() - base), 32'd2);
    if (order_log.size() - base == 2)
      check("t6_spacing", 32'(cyc_log[base + 1] - cyc_log[base]), 32'd3);
    pq0.push_back(mk(1'b0, 32'd100, 32'd0, 1'b1));
    pq0.push_back(mk(1'b0, 32'd101, 32'd0, 1'b1));
    wait_idle(30);
    check("t6_rdata0", rdata0, 32'hBBBB_0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the data memory block (dmemory).
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader, which also writes the LED segment word.
- Serialises requests with round-robin arbitration and drives the memory's mem_read/mem_write strobes with correct spacing.
- Returns read data and completion pulses to the winning requester.

Parameters:
- WIDTH, 32, data and address width; matches dmemory.
- DEPTH, 1024, number of memory words; addresses at or above DEPTH are illegal.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0, req1  input  1 each  request valid; held high and stable until the matching done/err
- we0, we1  input  1 each  1 = write, 0 = read
- addr0, addr1  input  WIDTH each  word address
- wdata0, wdata1  input  WIDTH each  write data
- done0, done1  output  1 each  one-cycle completion pulse
- err0, err1  output  1 each  one-cycle pulse: address out of range, no memory access
- rdata0, rdata1  output  WIDTH each  read data, valid while done is high for a read
- busy  output  1  arbiter not in IDLE
- mem_read, mem_write  output  1 each  to dmemory; never both 1
- read_address, write_address  output  WIDTH each  to dmemory; both carry the latched address
- write_data  output  WIDTH  to dmemory
- mem_data  input  WIDTH  from dmemory; valid one cycle after mem_read is sampled

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - All done/err/mem strobes/busy = 0.
  - Addresses, write_data and rdata = 0.
  - last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - With no req, stay in IDLE.
  - With one req, that port wins.
  - With both reqs, the port not equal to last_grant wins.
  - Latch winner id, we, addr and wdata; set last_grant to the winner.
  - If addr >= DEPTH: pulse err_winner next cycle and stay in IDLE; last_grant still updates.
  - Otherwise go to ACCESS; next cycle assert mem_write or mem_read for exactly one cycle.
- ACCESS:
  - Write: dmemory latches the data this cycle. Pulse done_winner next cycle and return to IDLE.
  - Read: go to RDWAIT.
- RDWAIT: capture mem_data into rdata_winner, pulse done_winner next cycle, return to IDLE.
- Latency, with request seen in IDLE at cycle T:
  - Memory strobe at T+1.
  - Write done at T+2.
  - Read done and rdata at T+3.
  - Error pulse at T+1.
- Throughput:
  - The cycle in which done is high is also an IDLE cycle, so a new request can be sampled in that same cycle.
  - Requester rule: req must be deasserted, or changed to a new request, in the cycle after done. The arbiter does not re-sample the winner's req in the done cycle; it first samples in the following IDLE cycle.
- rdata_x holds its last value between reads; it is meaningful only while done_x is high.
- Requests that change while not granted are ignored until sampled in IDLE.
- Reset mid-operation: the FSM aborts to IDLE and no done is issued for the aborted request.
  - A write already strobed may or may not have reached memory; the requester must reissue it.
- mem_read and mem_write are never both high. Neither strobe is high in IDLE or RDWAIT.

Decomposition:
- Shared package/include (config.v):
  - state encodings: IDLE=2'd0, ACCESS=2'd1, RDWAIT=2'd2
  - port id constants: PORT_CPU=1'b0, PORT_DBG=1'b1
  - LED_SEG_ADDRESS, existing
- Sub-module rr_pick2 (combinational two-way round-robin select).
  - Inputs: req0, req1, last_grant.
  - Outputs: valid, winner.
  - Reused by later bus arbiters.

Test Plan:
1. Single read: mem[5]=32'hDEAD_BEEF; req0=1, we0=0, addr0=5 at T → mem_read=1 and read_address=5 at T+1 only; done0=1 and rdata0=32'hDEAD_BEEF at T+3; done1 never high.
2. Write then read: req1 writes 32'h1234 to addr 10'h3FF → mem_write=1 at T+1, done1 at T+2; then req0 reads 10'h3FF → rdata0=32'h1234.
3. Contention: req0 and req1 both held for repeated reads from reset → grants alternate 0,1,0,1 across four transactions; each done preceded by exactly one mem_read strobe.
4. Out of range: req0 write to addr 1024 → err0 at T+1; mem_write never asserted; the next tie is won by port 1.
5. Reset mid-read: assert reset in the RDWAIT cycle → next cycle busy=0, done0=0 and no later done0; a fresh read then completes normally with 3-cycle latency.
6. Back-to-back writes from port 0, with a new addr presented the cycle after each done → two mem_write strobes with correct addresses; done pulses spaced 3 cycles apart.
